// File: rtl/watch_time_counter.sv
// Time-of-day keeper: divides clk to one-second ticks and holds HH:MM:SS as
// six BCD digits (24-hour). Set mode freezes seconds at 00 and lets the hour
// and minute buttons step the time, one increment per button press.
module watch_time_counter #(
   parameter int TICKS_PER_SEC = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       setMode,
   input  logic       incHour,
   input  logic       incMin,
   output logic [3:0] curHour1,
   output logic [3:0] curHour0,
   output logic [3:0] curMin1,
   output logic [3:0] curMin0,
   output logic [3:0] curSec1,
   output logic [3:0] curSec0,
   output logic       secTick,
   output logic       minTick
);

   // Smallest prescaler that still holds TICKS_PER_SEC-1.
   localparam int unsigned PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

   // Each time field is kept as {tens, units} BCD.
   logic [7:0]    hour_q, minute_q, second_q;
   logic [7:0]    hour_n, minute_n, second_n;
   logic [PW-1:0] presc_q, presc_n;
   logic          inc_hour_q, inc_min_q;
   logic          sec_tick_q, min_tick_q;
   logic          sec_tick_n, min_tick_n;
   logic          term, hour_press, min_press;

   // BCD 00..59 increment, 59 wraps to 00.
   function automatic logic [7:0] inc_60(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
      end else begin
         r[7:4] = v[7:4];
         r[3:0] = v[3:0] + 4'd1;
      end
      return r;
   endfunction

   // BCD 00..23 increment, 23 wraps to 00.
   function automatic logic [7:0] inc_24(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h23) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r[7:4] = v[7:4] + 4'd1;
         r[3:0] = 4'd0;
      end else begin
         r[7:4] = v[7:4];
         r[3:0] = v[3:0] + 4'd1;
      end
      return r;
   endfunction

   // Next-state: set-mode increments or run-mode ripple carry, plus pulses.
   always_comb begin
      term       = (presc_q == TERM);
      hour_press = setMode & incHour & ~inc_hour_q;
      min_press  = setMode & incMin & ~inc_min_q;
      hour_n     = hour_q;
      minute_n   = minute_q;
      second_n   = second_q;
      presc_n    = presc_q;
      sec_tick_n = 1'b0;
      if (setMode) begin
         // Set mode wins over a coincident terminal count.
         presc_n  = '0;
         second_n = 8'h00;
         if (min_press) minute_n = inc_60(minute_q);   // no carry into hour
         if (hour_press) hour_n = inc_24(hour_q);
      end else if (term) begin
         presc_n    = '0;
         sec_tick_n = 1'b1;
         second_n   = inc_60(second_q);
         if (second_q == 8'h59) begin
            minute_n = inc_60(minute_q);
            if (minute_q == 8'h59) hour_n = inc_24(hour_q);
         end
      end else begin
         presc_n = presc_q + PW'(1);
      end
      // One pulse for any HH:MM change, even when both fields move.
      min_tick_n = ({hour_n, minute_n} != {hour_q, minute_q});
   end

   // State register: time digits, prescaler, button history and pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         hour_q     <= 8'h00;
         minute_q   <= 8'h00;
         second_q   <= 8'h00;
         presc_q    <= '0;
         inc_hour_q <= 1'b0;
         inc_min_q  <= 1'b0;
         sec_tick_q <= 1'b0;
         min_tick_q <= 1'b0;
      end else begin
         hour_q     <= hour_n;
         minute_q   <= minute_n;
         second_q   <= second_n;
         presc_q    <= presc_n;
         inc_hour_q <= incHour;
         inc_min_q  <= incMin;
         sec_tick_q <= sec_tick_n;
         min_tick_q <= min_tick_n;
      end
   end

   assign curHour1 = hour_q[7:4];
   assign curHour0 = hour_q[3:0];
   assign curMin1  = minute_q[7:4];
   assign curMin0  = minute_q[3:0];
   assign curSec1  = second_q[7:4];
   assign curSec0  = second_q[3:0];
   assign secTick  = sec_tick_q;
   assign minTick  = min_tick_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter: integer time-of-day reference model feeding
// an expected queue, plus directed checks of the key scenarios.
module tb_watch_time_counter;

   localparam int TPS = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       setMode = 1'b0;
   logic       incHour = 1'b0;
   logic       incMin = 1'b0;
   logic [3:0] curHour1, curHour0, curMin1, curMin0, curSec1, curSec0;
   logic       secTick, minTick;

   logic [25:0] dut_word;
   logic [23:0] dut_time;
   logic [25:0] exp_q[$];

   int n_checks = 0;
   int n_fail = 0;

   // Reference model state (plain integers, not BCD).
   int m_h = 0, m_m = 0, m_s = 0, m_cnt = 0;
   bit m_hq = 0, m_mq = 0, m_st = 0, m_mt = 0;

   watch_time_counter #(.TICKS_PER_SEC(TPS)) dut (
      .clk(clk), .reset(reset), .setMode(setMode), .incHour(incHour), .incMin(incMin),
      .curHour1(curHour1), .curHour0(curHour0), .curMin1(curMin1), .curMin0(curMin0),
      .curSec1(curSec1), .curSec0(curSec0), .secTick(secTick), .minTick(minTick)
   );

   assign dut_word = {curHour1, curHour0, curMin1, curMin0, curSec1, curSec0, secTick, minTick};
   assign dut_time = dut_word[25:2];

   // Clock generation.
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit sm, input bit ih, input bit im);
      int oh, om, t;
      if (r) begin
         m_h = 0; m_m = 0; m_s = 0; m_cnt = 0;
         m_hq = 0; m_mq = 0; m_st = 0; m_mt = 0;
      end else begin
         oh = m_h;
         om = m_m;
         m_st = 0;
         if (sm) begin
            m_cnt = 0;
            m_s = 0;
            if (im && !m_mq) m_m = (m_m + 1) % 60;
            if (ih && !m_hq) m_h = (m_h + 1) % 24;
         end else if (m_cnt == TPS - 1) begin
            m_cnt = 0;
            t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = t / 3600;
            m_m = (t / 60) % 60;
            m_s = t % 60;
            m_st = 1;
         end else begin
            m_cnt++;
         end
         m_hq = ih;
         m_mq = im;
         m_mt = (m_h != oh) || (m_m != om);
      end
   endtask

   function automatic logic [25:0] model_word();
      return {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10),
              4'(m_s / 10), 4'(m_s % 10), m_st, m_mt};
   endfunction

   // Drive one cycle of stimulus, queue the model result, compare after the edge.
   task automatic cycle(input bit r, input bit sm, input bit ih, input bit im);
      logic [25:0] exp_w;
      @(negedge clk);
      reset = r; setMode = sm; incHour = ih; incMin = im;
      model_step(r, sm, ih, im);
      exp_q.push_back(model_word());
      @(posedge clk);
      #1;
      exp_w = exp_q.pop_front();
      check("cycle", {6'd0, dut_word}, {6'd0, exp_w});
   endtask

   task automatic press_hour(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(0, 1, 1, 0);
         cycle(0, 1, 0, 0);
      end
   endtask

   task automatic press_min(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(0, 1, 0, 1);
         cycle(0, 1, 0, 0);
      end
   endtask

   task automatic run_sec(input int n);
      for (int i = 0; i < n * TPS; i++) cycle(0, 0, 0, 0);
   endtask

   // Stimulus sequence.
   initial begin
      int mt_count;
      int found;

      // Reset and first tick.
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      check("reset_time", dut_time, 24'h000000);
      check("reset_ticks", {secTick, minTick}, 2'b00);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 0);
         check("pre_tick", secTick, 1'b0);
      end
      cycle(0, 0, 0, 0);
      check("first_tick", secTick, 1'b1);
      check("first_tick_time", dut_time, 24'h000001);
      check("first_tick_min", minTick, 1'b0);

      // Day wrap.
      cycle(0, 1, 0, 0);
      press_hour(23);
      press_min(59);
      check("set_2359", dut_time, 24'h235900);
      run_sec(58);
      check("at_235958", dut_time, 24'h235958);
      mt_count = 0;
      for (int i = 0; i < TPS; i++) begin
         cycle(0, 0, 0, 0);
         mt_count += int'(minTick);
      end
      check("at_235959", dut_time, 24'h235959);
      for (int i = 0; i < TPS; i++) begin
         cycle(0, 0, 0, 0);
         mt_count += int'(minTick);
      end
      check("day_wrap", dut_time, 24'h000000);
      check("wrap_mintick_count", mt_count, 1);

      // Minute carry from 12:09:59.
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      press_hour(12);
      press_min(9);
      run_sec(59);
      check("at_120959", dut_time, 24'h120959);
      run_sec(1);
      check("min_carry", dut_time, 24'h121000);
      check("min_carry_ticks", {secTick, minTick}, 2'b11);

      // Set-mode increments from 09:59:30.
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      press_hour(9);
      press_min(59);
      run_sec(30);
      check("at_095930", dut_time, 24'h095930);
      cycle(0, 1, 0, 0);
      check("set_sec_clear", dut_time, 24'h095900);
      cycle(0, 1, 0, 1);
      check("min_wrap", dut_time, 24'h090000);
      check("min_wrap_tick", minTick, 1'b1);
      cycle(0, 1, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0);
      check("held_hour", dut_time, 24'h100000);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 1);
      check("both_press", dut_time, 24'h110100);
      check("both_press_tick", minTick, 1'b1);

      // Ignored presses, setMode on terminal count, prescaler restart.
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
      check("ignored_press", dut_time, 24'h110100);
      cycle(0, 0, 0, 0);
      check("run_tick", dut_time, 24'h110101);
      for (int i = 0; i < 3 * TPS && m_cnt != TPS - 1; i++) cycle(0, 0, 0, 0);
      check("reach_term", m_cnt, TPS - 1);
      cycle(0, 1, 0, 0);
      check("set_on_term", dut_time, 24'h110100);
      check("set_on_term_tick", secTick, 1'b0);
      found = 0;
      for (int i = 1; i <= 3 * TPS; i++) begin
         cycle(0, 0, 0, 0);
         if (secTick === 1'b1) begin
            found = i;
            break;
         end
      end
      check("restart_latency", found, TPS);

      // Reset mid-operation at 17:42:33, prescaler 2.
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      press_hour(17);
      press_min(42);
      run_sec(33);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      check("at_174233", dut_time, 24'h174233);
      cycle(1, 0, 0, 0);
      check("mid_reset", dut_time, 24'h000000);
      check("mid_reset_ticks", {secTick, minTick}, 2'b00);

      // Button held while reset deasserts in set mode counts as one press.
      cycle(1, 1, 1, 1);
      cycle(0, 1, 1, 1);
      check("held_through_reset", dut_time, 24'h010100);

      // Random mixed stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
